// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (logical/arithmetic) with a start/busy/done handshake and ALU flags.
// Define SHIFT_RIGHT_FAST_EN to move up to four bits per clock instead of one.
module shift_right_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] busA,
   input  logic [AMT_W-1:0] amount,
   input  logic             arith,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dataOut,
   output logic             zeroFlag,
   output logic             overflowFlag,
   output logic             carryoutFlag,
   output logic             negativeFlag
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   stateT            state;
   logic [AMT_W-1:0] counter;
   logic             mode;
   logic             flagValid;

   logic [AMT_W-1:0] stepAmt;
   logic [WIDTH-1:0] shiftNext;
   logic             carryNext;
   logic             lastStep;

`ifdef SHIFT_RIGHT_FAST_EN
   localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(4);

   // Step of min(counter, 4) bits; carry is the last bit leaving the word.
   always_comb begin
      stepAmt   = (counter > STEP_MAX) ? STEP_MAX : counter;
      shiftNext = mode ? WIDTH'($signed(dataOut) >>> stepAmt) : (dataOut >> stepAmt);
      carryNext = (stepAmt == '0) ? 1'b0 : dataOut[stepAmt - AMT_W'(1)];
      lastStep  = (counter <= STEP_MAX);
   end
`else
   // One bit per clock, fill from the sign bit in arithmetic mode.
   always_comb begin
      stepAmt   = AMT_W'(1);
      shiftNext = {(mode & dataOut[WIDTH-1]), dataOut[WIDTH-1:1]};
      carryNext = dataOut[0];
      lastStep  = (counter == AMT_W'(1));
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         dataOut      <= '0;
         carryoutFlag <= 1'b0;
         counter      <= '0;
         mode         <= 1'b0;
         flagValid    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dataOut      <= busA;
                  counter      <= amount;
                  mode         <= arith;
                  carryoutFlag <= 1'b0;
                  flagValid    <= 1'b1;
                  busy         <= 1'b1;
                  if (amount == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               dataOut      <= shiftNext;
               carryoutFlag <= carryNext;
               counter      <= counter - stepAmt;
               if (lastStep) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Z/N are derived from the registered result; gated so both read 0 out of reset.
   assign zeroFlag     = flagValid & (dataOut == '0);
   assign negativeFlag = flagValid & dataOut[WIDTH-1];
   assign overflowFlag = 1'b0;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq: latency, results, flags, ignored starts, reset abort.
module tb_shift_right_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] busA;
   logic [4:0]  amount;
   logic        arith;
   logic        busy;
   logic        done;
   logic [31:0] dataOut;
   logic        zeroFlag;
   logic        overflowFlag;
   logic        carryoutFlag;
   logic        negativeFlag;

   int nCompared = 0;
   int nMismatch = 0;

   shift_right_seq #(.WIDTH(32), .AMT_W(5)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .busA         (busA),
      .amount       (amount),
      .arith        (arith),
      .busy         (busy),
      .done         (done),
      .dataOut      (dataOut),
      .zeroFlag     (zeroFlag),
      .overflowFlag (overflowFlag),
      .carryoutFlag (carryoutFlag),
      .negativeFlag (negativeFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int expLatency(input int n);
`ifdef SHIFT_RIGHT_FAST_EN
      return (n + 3) / 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation, scramble inputs after acceptance, then check done cycle and hold cycle.
   task automatic runOp(input string tag, input logic [31:0] a, input logic [4:0] amt,
                        input logic ar, input logic [31:0] expData, input logic expC);
      int cyc;
      busA = a; amount = amt; arith = ar; start = 1'b1;
      tick();
      start = 1'b0; busA = $urandom; amount = 5'($urandom); arith = ~ar;
      cyc = 1;
      while (done !== 1'b1 && cyc < 80) begin
         tick();
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(expLatency(int'(amt))));
      check({tag, " done"},    32'(done), 32'd1);
      check({tag, " busy"},    32'(busy), 32'd1);
      check({tag, " data"},    dataOut, expData);
      check({tag, " C"},       32'(carryoutFlag), 32'(expC));
      check({tag, " Z"},       32'(zeroFlag), 32'(expData == 32'd0));
      check({tag, " N"},       32'(negativeFlag), 32'(expData[31]));
      check({tag, " V"},       32'(overflowFlag), 32'd0);
      tick();
      check({tag, " done drop"}, 32'(done), 32'd0);
      check({tag, " busy drop"}, 32'(busy), 32'd0);
      check({tag, " data hold"}, dataOut, expData);
      check({tag, " C hold"},    32'(carryoutFlag), 32'(expC));
   endtask

   initial begin
      int cyc;
      logic sawDone;
      reset_n = 1'b0; start = 1'b0; busA = '0; amount = '0; arith = 1'b0;
      tick();
      tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst data", dataOut, 32'd0);
      check("rst flags", {28'd0, zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle busy", 32'(busy), 32'd0);

      runOp("lsr1",   32'hF0F0F0F0, 5'd1,  1'b0, 32'h78787878, 1'b0);
      runOp("asr4",   32'hF0F0F0F0, 5'd4,  1'b1, 32'hFF0F0F0F, 1'b0);
      runOp("amt0",   32'hF0F0F0F0, 5'd0,  1'b0, 32'hF0F0F0F0, 1'b0);
      runOp("lsr31",  32'h40000000, 5'd31, 1'b0, 32'h00000000, 1'b1);
      runOp("asr31",  32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
      runOp("asr9",   32'hF0F0F0F0, 5'd9,  1'b1, 32'hFFF87878, 1'b0);
      runOp("lsr5c",  32'h00000010, 5'd5,  1'b0, 32'h00000000, 1'b1);
      runOp("asr2p",  32'h7000000E, 5'd2,  1'b1, 32'h1C000003, 1'b1);

      // Starts while busy (mid-shift and in DONE) must be ignored.
      busA = 32'hF0F0F0F0; amount = 5'd10; arith = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 80) begin
         if (cyc == 3) begin
            busA = 32'hFFFFFFFF; amount = 5'd1; arith = 1'b1; start = 1'b1;
         end
         tick();
         start = 1'b0;
         cyc++;
      end
      check("ign latency", 32'(cyc), 32'(expLatency(10)));
      check("ign data", dataOut, 32'h003C3C3C);
      busA = 32'h12345678; amount = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("ign done-start busy", 32'(busy), 32'd0);
      check("ign done-start data", dataOut, 32'h003C3C3C);
      tick();
      check("ign no restart", 32'(done), 32'd0);

      // Reset mid-shift aborts immediately with no done.
      busA = 32'hAAAAAAAA; amount = 5'd20; arith = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort data", dataOut, 32'd0);
      check("abort flags", {28'd0, zeroFlag, overflowFlag, carryoutFlag, negativeFlag}, 32'd0);
      tick();
      reset_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (done === 1'b1) sawDone = 1'b1;
      end
      check("abort no done", 32'(sawDone), 32'd0);
      check("abort idle", 32'(busy), 32'd0);

      runOp("post", 32'h0000000F, 5'd3, 1'b0, 32'h00000001, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter; the companion to the ALU left-shift unit.
- Accepts a WIDTH-bit operand, a shift amount and a logical/arithmetic mode.
- Shifts one bit per clock under a start/busy/done handshake.
- Produces the same four ALU flags (zero, overflow, carryout, negative) for the ALU flag mux.

Parameters:
WIDTH, 32, operand and result width in bits
AMT_W, 5, shift-amount width; fixed at clog2(WIDTH), so amount is always less than WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
busA  input  WIDTH  operand
amount  input  AMT_W  right-shift distance, 0..WIDTH-1
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; result and flags valid
dataOut  output  WIDTH  shifted result, registered
zeroFlag  output  1  dataOut == 0
overflowFlag  output  1  always 0
carryoutFlag  output  1  last bit shifted out
negativeFlag  output  1  dataOut[WIDTH-1]

Behaviour:
- Reset (async assert, clk-synchronous deassert), all outputs 0:
  - state=IDLE; busy=0, done=0, dataOut=0.
  - zeroFlag=0, overflowFlag=0, carryoutFlag=0, negativeFlag=0.
  - Internal counter=0.
- Reset mid-operation aborts immediately; no done is produced.
- States:
  - IDLE: busy=0.
    - On the edge with start=1: load dataOut<=busA, counter<=amount, mode<=arith, carryoutFlag<=0.
    - If amount==0, go to DONE; otherwise go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - carryoutFlag<=dataOut[0].
    - dataOut<={fill, dataOut[WIDTH-1:1]}, where fill = mode ? dataOut[WIDTH-1] : 0.
    - counter<=counter-1.
    - When counter reaches 1 on this edge, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - Start sampled at edge E0.
  - done is high in the cycle after edge E0+N for N=amount≥1; it is high in the cycle after E0 for N=0.
  - Total N+1 cycles start-edge to done-cycle, N=0 counts as 1.
- Flags:
  - zeroFlag and negativeFlag are combinational from registered dataOut.
  - Flags are valid whenever done=1 and hold until the next accepted start.
  - carryoutFlag = busA[amount-1] for amount≥1; 0 for amount=0.
  - overflowFlag is tied 0.
- Results: dataOut and flags hold their final values in IDLE until the next accepted start.
- start while busy=1, including in the DONE cycle, is ignored; no queuing.
- busA, amount and arith may change freely after the accepting edge; they are captured at start.
- amount=WIDTH-1:
  - Logical: result has at most bit0 set.
  - Arithmetic: result is all sign bits.

Optional Feature:
- Macro SHIFT_RIGHT_FAST_EN.
- When defined, SHIFT moves min(counter,4) bits per edge.
  - carryoutFlag takes the last bit shifted out in that step.
  - Latency becomes ceil(N/4)+1 cycles, N=0 still 1.
  - Results and flags are identical to the baseline.
- When undefined, the block shifts 1 bit per edge as above.

Test Plan:
- busA=F0F0F0F0, amount=1, arith=0, start pulse -> done one cycle after SHIFT edge (2 cycles total); dataOut=78787878, C=0, N=0, Z=0, V=0.
- busA=F0F0F0F0, amount=4, arith=1 -> done after 5 cycles; dataOut=FF0F0F0F, C=0, N=1, Z=0.
- busA=F0F0F0F0, amount=0 -> done 1 cycle after start; dataOut=F0F0F0F0, C=0, N=1; busy high for exactly 1 cycle.
- busA=40000000, amount=31, arith=0 -> dataOut=00000000, Z=1, C=1, done after 32 cycles; repeat with arith=1, busA=80000000 -> FFFFFFFF, N=1, C=0.
- Start with amount=10; pulse start again with new data at cycles 3 and in DONE -> both ignored, first result only; then assert reset_n=0 mid-shift of a second op -> all outputs 0 immediately, no done, IDLE on release.
- With SHIFT_RIGHT_FAST_EN: busA=F0F0F0F0, amount=9, arith=1 -> done after 4 cycles; dataOut=FFF87878, C=0.
